// File: rtl/miriscv_defines.sv
// Shared definitions for the miriscv load/store path: access size codes,
// LSU FSM state encodings and small size-decoding helpers.
package miriscv_defines;

  // Load/store size codes as carried by lsu_size_i
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // LSU FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4,
    DONE = 3'd5
  } lsu_state_e;

  // Halfword access (signed or unsigned)
  function automatic logic ldst_is_half(input logic [2:0] size);
    return (size == LDST_H) || (size == LDST_HU);
  endfunction

  // Byte access (signed or unsigned)
  function automatic logic ldst_is_byte(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_BU);
  endfunction

  // Byte-enable mask of an access before lane shifting.
  // Unknown size codes are treated as full words.
  function automatic logic [3:0] ldst_mask(input logic [2:0] size);
    logic [3:0] mask;
    if (ldst_is_byte(size)) begin
      mask = 4'b0001;
    end else if (ldst_is_half(size)) begin
      mask = 4'b0011;
    end else begin
      mask = 4'b1111;
    end
    return mask;
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane alignment for a one- or two-beat memory access:
// byte enables and shifted store data for both beats, plus extraction and
// sign/zero extension of load data from the two captured beats.
module miriscv_lsu_align
  import miriscv_defines::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [6:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [63:0] rdata_wide;
  logic [31:0] rdata_win;

  // Mask shifted across a 7-bit window: the low nibble is beat 0, the bits
  // that spill past bit 3 belong to the following word (beat 1).
  assign be_wide = {3'b000, ldst_mask(size)} << offset;
  assign be_lo   = be_wide[3:0];
  assign be_hi   = {1'b0, be_wide[6:4]};

  // Store data placed in a 64-bit window; the upper half is exactly
  // store_data >> 8*(4-offset), which is zero for aligned accesses.
  assign wdata_wide = {32'h0, store_data} << {offset, 3'b000};
  assign wdata_lo   = wdata_wide[31:0];
  assign wdata_hi   = wdata_wide[63:32];

  // Load data: the two beats form one 64-bit value, read from the byte offset
  assign rdata_wide = {rdata_hi, rdata_lo};
  assign rdata_win  = rdata_wide[{offset, 3'b000} +: 32];

  // Extract the addressed bytes and extend according to the size code
  always_comb begin
    load_data = rdata_win;
    case (size)
      LDST_B:  load_data = {{24{rdata_win[7]}}, rdata_win[7:0]};
      LDST_BU: load_data = {24'h0, rdata_win[7:0]};
      LDST_H:  load_data = {{16{rdata_win[15]}}, rdata_win[15:0]};
      LDST_HU: load_data = {16'h0, rdata_win[15:0]};
      default: load_data = rdata_win;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu_split.sv
// Load/store unit: turns core byte/halfword/word requests into req/gnt/rvalid
// memory transactions, splitting word-crossing accesses into two beats (or
// flagging them as misaligned), with an optional per-beat timeout.
module miriscv_lsu_split
  import miriscv_defines::*;
#(
  parameter int unsigned MISALIGN_SPLIT = 1,
  parameter int unsigned TIMEOUT        = 0
) (
  input  logic        clk_i,
  input  logic        arst_i,
  // core side
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  // memory side
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value in the last allowed cycle of a beat
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  lsu_state_e       state_reg;
  lsu_state_e       state_next;

  logic [29:0]      word_addr_reg;
  logic [1:0]       offset_reg;
  logic [2:0]       size_reg;
  logic             we_reg;
  logic [31:0]      store_data_reg;
  logic             split_reg;
  logic [31:0]      beat0_reg;
  logic [31:0]      beat1_reg;
  logic [31:0]      load_data_reg;
  logic             misalign_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             is_half_in;
  logic             is_word_in;
  logic             cross_in;
  logic             misalign_in;
  logic             accept;
  logic             busy;
  logic             in_rsp;
  logic             req_active;
  logic             timeout_hit;
  logic             load_done;

  logic [31:0]      merge_lo;
  logic [31:0]      merge_hi;
  logic [3:0]       be_lo;
  logic [3:0]       be_hi;
  logic [31:0]      wdata_lo;
  logic [31:0]      wdata_hi;
  logic [31:0]      load_data;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE, where the inputs are latched)
  // ---------------------------------------------------------------------------
  assign is_half_in = ldst_is_half(lsu_size_i);
  assign is_word_in = !is_half_in && !ldst_is_byte(lsu_size_i);

  // Halfword at offset 3 or word at a non-zero offset spans two words
  assign cross_in = (is_half_in && (lsu_addr_i[1:0] == 2'b11)) ||
                    (is_word_in && (lsu_addr_i[1:0] != 2'b00));

  // Without splitting, natural alignment is required (so H at offset 1
  // is rejected even though it would fit in one word)
  assign misalign_in = (MISALIGN_SPLIT == 0) &&
                       ((is_half_in && lsu_addr_i[0]) ||
                        (is_word_in && (lsu_addr_i[1:0] != 2'b00)));

  assign accept = (state_reg == IDLE) && lsu_req_i;

  assign busy   = (state_reg == REQ0) || (state_reg == RSP0) ||
                  (state_reg == REQ1) || (state_reg == RSP1);
  assign in_rsp = (state_reg == RSP0) || (state_reg == RSP1);

  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_reg == CNT_LAST);

  // A load finishes normally when a response moves the FSM into DONE
  assign load_done = !we_reg && in_rsp && !timeout_hit && (state_next == DONE);

  // ---------------------------------------------------------------------------
  // Alignment datapath. The beat being answered is taken straight from the
  // bus so the merged load value is ready on the transition into DONE.
  // ---------------------------------------------------------------------------
  assign merge_lo = (state_reg == RSP0) ? data_rdata_i : beat0_reg;
  assign merge_hi = (state_reg == RSP1) ? data_rdata_i : beat1_reg;

  miriscv_lsu_align u_align (
    .size       (size_reg),
    .offset     (offset_reg),
    .store_data (store_data_reg),
    .rdata_lo   (merge_lo),
    .rdata_hi   (merge_hi),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .wdata_lo   (wdata_lo),
    .wdata_hi   (wdata_hi),
    .load_data  (load_data)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a timeout overrides any handshake in the same cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (lsu_req_i) begin
          state_next = misalign_in ? DONE : REQ0;
        end
      end
      REQ0: begin
        if (timeout_hit) begin
          state_next = DONE;
        end else if (data_gnt_i) begin
          state_next = RSP0;
        end
      end
      RSP0: begin
        if (timeout_hit) begin
          state_next = DONE;
        end else if (data_rvalid_i) begin
          state_next = split_reg ? REQ1 : DONE;
        end
      end
      REQ1: begin
        if (timeout_hit) begin
          state_next = DONE;
        end else if (data_gnt_i) begin
          state_next = RSP1;
        end
      end
      RSP1: begin
        if (timeout_hit || data_rvalid_i) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Latch the request, capture response beats, count beat cycles and
  // register the load result and the one-cycle status flags
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      word_addr_reg  <= '0;
      offset_reg     <= '0;
      size_reg       <= '0;
      we_reg         <= 1'b0;
      store_data_reg <= '0;
      split_reg      <= 1'b0;
      beat0_reg      <= '0;
      beat1_reg      <= '0;
      load_data_reg  <= '0;
      misalign_reg   <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      if (accept) begin
        word_addr_reg  <= lsu_addr_i[31:2];
        offset_reg     <= lsu_addr_i[1:0];
        size_reg       <= lsu_size_i;
        we_reg         <= lsu_we_i;
        store_data_reg <= lsu_data_i;
        split_reg      <= cross_in;
      end

      if ((state_reg == RSP0) && data_rvalid_i) begin
        beat0_reg <= data_rdata_i;
      end
      if ((state_reg == RSP1) && data_rvalid_i) begin
        beat1_reg <= data_rdata_i;
      end

      // Counter restarts on every state change so each beat gets a full budget
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (busy && (TIMEOUT != 0)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (load_done) begin
        load_data_reg <= load_data;
      end

      // Both flags are only ever set on entry to DONE, which lasts one cycle
      misalign_reg <= accept && misalign_in;
      err_reg      <= timeout_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side outputs: decoded from the state register, zero when no beat
  // is being requested so nothing leaks onto the bus in other states
  // ---------------------------------------------------------------------------
  assign req_active = (state_reg == REQ0) || (state_reg == REQ1);

  // Select beat 0 or beat 1 address, enables and data
  always_comb begin
    data_addr_o  = 32'h0;
    data_be_o    = 4'b0000;
    data_wdata_o = 32'h0;
    if (state_reg == REQ0) begin
      data_addr_o  = {word_addr_reg, 2'b00};
      data_be_o    = be_lo;
      data_wdata_o = wdata_lo;
    end else if (state_reg == REQ1) begin
      data_addr_o  = {word_addr_reg + 30'd1, 2'b00};
      data_be_o    = be_hi;
      data_wdata_o = wdata_hi;
    end
  end

  assign data_req_o = req_active;
  assign data_we_o  = req_active && we_reg;

  // ---------------------------------------------------------------------------
  // Core-side outputs
  // ---------------------------------------------------------------------------
  assign lsu_stall_req_o = lsu_req_i && (state_reg != DONE);
  assign lsu_data_o      = load_data_reg;
  assign lsu_misalign_o  = misalign_reg;
  assign lsu_err_o       = err_reg;

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Directed bench for miriscv_lsu_split: one split-mode instance with a
// 4-cycle timeout and one non-split instance. The bench acts as core and
// memory; expected bus beats and load results go into scoreboard queues when
// an access is issued and are popped as the DUT produces them.
module tb_miriscv_lsu_split;
  import miriscv_defines::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  logic        clk_i;
  logic        arst_i;
  logic        req_a, req_b;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_data;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        a_stall, a_mis, a_err, a_req, a_we;
  logic [31:0] a_data, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_stall, b_mis, b_err, b_req, b_we;
  logic [31:0] b_data, b_addr, b_wdata;
  logic [3:0]  b_be;

  logic        o_stall, o_mis, o_err, o_req, o_we;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0]  o_be;

  int checks   = 0;
  int failures = 0;

  beat_t       sb_beats[$];
  logic [31:0] sb_res[$];

  miriscv_lsu_split #(.MISALIGN_SPLIT(1), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .lsu_req_i(req_a), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_stall_req_o(a_stall), .lsu_data_o(a_data),
    .lsu_misalign_o(a_mis), .lsu_err_o(a_err),
    .data_req_o(a_req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_rdata_i(rdata), .data_we_o(a_we), .data_be_o(a_be),
    .data_addr_o(a_addr), .data_wdata_o(a_wdata)
  );

  miriscv_lsu_split #(.MISALIGN_SPLIT(0), .TIMEOUT(4)) dut_ns (
    .clk_i(clk_i), .arst_i(arst_i),
    .lsu_req_i(req_b), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_stall_req_o(b_stall), .lsu_data_o(b_data),
    .lsu_misalign_o(b_mis), .lsu_err_o(b_err),
    .data_req_o(b_req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
    .data_rdata_i(rdata), .data_we_o(b_we), .data_be_o(b_be),
    .data_addr_o(b_addr), .data_wdata_o(b_wdata)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      o_stall = a_stall; o_mis = a_mis; o_err = a_err; o_req = a_req; o_we = a_we;
      o_data = a_data; o_addr = a_addr; o_wdata = a_wdata; o_be = a_be;
    end else begin
      o_stall = b_stall; o_mis = b_mis; o_err = b_err; o_req = b_req; o_we = b_we;
      o_data = b_data; o_addr = b_addr; o_wdata = b_wdata; o_be = b_be;
    end
  endtask

  task automatic push_beat(input logic [31:0] addr, input logic [3:0] be,
                           input logic we, input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    sb_beats.push_back(b);
  endtask

  // Drive one core access and play the memory; abort_rsp1 pulses arst_i
  // while the second beat waits for its response.
  task automatic run_access(input string name, input int sel, input logic we,
                            input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd0,
                            input logic [31:0] rd1, input logic grant_en,
                            input logic abort_rsp1, input int exp_stall,
                            input logic exp_mis, input logic exp_err,
                            input int exp_req);
    int stall_cnt = 0, req_cnt = 0, we_cnt = 0, granted = 0, cyc = 0;
    logic pending = 1'b0, seen = 1'b0, done = 1'b0, aborted = 1'b0;
    beat_t eb;
    logic [31:0] lane;
    logic [31:0] exp_res;

    lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_data = wdata;
    if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
    #1;
    sample(sel);
    if (o_stall) stall_cnt++;

    while (!done && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      sample(sel);
      gnt = 1'b0;
      rvalid = 1'b0;
      if (!o_stall) begin
        done = 1'b1;
        chk({name, "_misalign"}, 32'(o_mis), 32'(exp_mis));
        chk({name, "_err"}, 32'(o_err), 32'(exp_err));
        chk({name, "_res_queue"}, 32'(sb_res.size() > 0), 32'd1);
        if (sb_res.size() > 0) begin
          exp_res = sb_res.pop_front();
          chk({name, "_lsu_data"}, o_data, exp_res);
        end
        req_a = 1'b0;
        req_b = 1'b0;
      end else begin
        stall_cnt++;
        if (o_req) begin
          req_cnt++;
          if (o_we) we_cnt++;
          if (!seen) begin
            seen = 1'b1;
            chk({name, "_beat_queue"}, 32'(sb_beats.size() > 0), 32'd1);
            if (sb_beats.size() > 0) begin
              eb = sb_beats.pop_front();
              chk({name, "_addr"}, o_addr, eb.addr);
              chk({name, "_be"}, {28'h0, o_be}, {28'h0, eb.be});
              chk({name, "_we"}, 32'(o_we), 32'(eb.we));
              if (eb.we) begin
                lane = {{8{eb.be[3]}}, {8{eb.be[2]}}, {8{eb.be[1]}}, {8{eb.be[0]}}};
                chk({name, "_wdata"}, o_wdata & lane, eb.wdata & lane);
              end
            end
          end
          if (grant_en) begin
            gnt = 1'b1;
            seen = 1'b0;
            pending = 1'b1;
            granted++;
          end
        end else if (pending) begin
          if (abort_rsp1 && granted == 2) begin
            arst_i = 1'b1;
            req_a = 1'b0;
            req_b = 1'b0;
            #1;
            sample(sel);
            chk({name, "_rst_req"}, 32'(o_req), 32'd0);
            chk({name, "_rst_we"}, 32'(o_we), 32'd0);
            chk({name, "_rst_be"}, {28'h0, o_be}, 32'd0);
            chk({name, "_rst_addr"}, o_addr, 32'd0);
            chk({name, "_rst_wdata"}, o_wdata, 32'd0);
            chk({name, "_rst_lsu_data"}, o_data, 32'd0);
            chk({name, "_rst_stall"}, 32'(o_stall), 32'd0);
            chk({name, "_rst_flags"}, {30'h0, o_mis, o_err}, 32'd0);
            @(negedge clk_i);
            arst_i = 1'b0;
            if (sb_res.size() > 0) exp_res = sb_res.pop_front();
            done = 1'b1;
            aborted = 1'b1;
          end else begin
            rvalid = 1'b1;
            rdata = (granted == 1) ? rd0 : rd1;
            pending = 1'b0;
          end
        end
      end
    end

    chk({name, "_completed"}, 32'(done), 32'd1);
    if (!done) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    if (done && !aborted) begin
      chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      chk({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
      chk({name, "_we_cycles"}, 32'(we_cnt), we ? 32'(exp_req) : 32'd0);
      chk({name, "_beats_left"}, 32'(sb_beats.size()), 32'd0);
      @(negedge clk_i);
      sample(sel);
      chk({name, "_flags_pulse"}, {30'h0, o_mis, o_err}, 32'd0);
    end
    $display("TXN %s sel=%0d we=%0d size=%0d addr=0x%08h stall=%0d req=%0d lsu_data=0x%08h",
             name, sel, we, size, addr, stall_cnt, req_cnt, o_data);
  endtask

  initial begin
    arst_i = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = '0; lsu_data = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;

    repeat (2) @(negedge clk_i);
    chk("reset_a_outputs", {a_stall, a_mis, a_err, a_req, a_we, 27'h0}, 32'd0);
    chk("reset_a_lsu_data", a_data, 32'd0);
    chk("reset_a_addr", a_addr, 32'd0);
    chk("reset_b_outputs", {b_stall, b_mis, b_err, b_req, b_we, b_be, 23'h0}, 32'd0);
    arst_i = 1'b0;
    @(negedge clk_i);

    // Single-beat word load, best case
    push_beat(32'h100, 4'b1111, 1'b0, 32'h0); sb_res.push_back(32'hDEADBEEF);
    run_access("lw_100", 0, 1'b0, LDST_W, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    // Byte loads from the top lane, signed then unsigned
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0); sb_res.push_back(32'hFFFFFF80);
    run_access("lb_103", 0, 1'b0, LDST_B, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0); sb_res.push_back(32'h00000080);
    run_access("lbu_103", 0, 1'b0, LDST_BU, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    // Split word store; load result register must hold the previous load
    push_beat(32'h100, 4'b1100, 1'b1, 32'h33440000);
    push_beat(32'h104, 4'b0011, 1'b1, 32'h00001122);
    sb_res.push_back(32'h00000080);
    run_access("sw_102", 0, 1'b1, LDST_W, 32'h102, 32'h11223344, 32'h0, 32'h0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 2);

    // Halfword in the upper lanes, sign-extended
    push_beat(32'h204, 4'b1100, 1'b0, 32'h0); sb_res.push_back(32'hFFFFBEEF);
    run_access("lh_206", 0, 1'b0, LDST_H, 32'h206, 32'h0, 32'hBEEF1234, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    // Halfword at offset 1 stays within one word
    push_beat(32'h200, 4'b0110, 1'b0, 32'h0); sb_res.push_back(32'h0000ABCD);
    run_access("lhu_201", 0, 1'b0, LDST_HU, 32'h201, 32'h0, 32'h00ABCD00, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    // Halfword at offset 3 splits across words
    push_beat(32'h200, 4'b1000, 1'b0, 32'h0);
    push_beat(32'h204, 4'b0001, 1'b0, 32'h0);
    sb_res.push_back(32'hFFFFA57F);
    run_access("lh_203", 0, 1'b0, LDST_H, 32'h203, 32'h0, 32'h7F000000, 32'h000000A5, 1'b1, 1'b0, 5, 1'b0, 1'b0, 2);

    // Split word load at offset 1
    push_beat(32'h100, 4'b1110, 1'b0, 32'h0);
    push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
    sb_res.push_back(32'h44332211);
    run_access("lw_101", 0, 1'b0, LDST_W, 32'h101, 32'h0, 32'h33221100, 32'h00000044, 1'b1, 1'b0, 5, 1'b0, 1'b0, 2);

    // Grant never arrives: 4 request cycles, then error pulse
    push_beat(32'h300, 4'b1111, 1'b0, 32'h0); sb_res.push_back(32'h44332211);
    run_access("lw_timeout", 0, 1'b0, LDST_W, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 4);

    // A stray late response while idle must be ignored
    rvalid = 1'b1; rdata = 32'hBAD0BAD0;
    @(negedge clk_i);
    rvalid = 1'b0;
    chk("late_rvalid_req", 32'(a_req), 32'd0);
    chk("late_rvalid_lsu_data", a_data, 32'h44332211);

    push_beat(32'h300, 4'b1111, 1'b0, 32'h0); sb_res.push_back(32'hCAFEF00D);
    run_access("lw_300", 0, 1'b0, LDST_W, 32'h300, 32'h0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    // Non-split instance: misaligned accesses produce no bus traffic
    sb_res.push_back(32'h0);
    run_access("ns_lh_203", 1, 1'b0, LDST_H, 32'h203, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);
    sb_res.push_back(32'h0);
    run_access("ns_sw_102", 1, 1'b1, LDST_W, 32'h102, 32'h11223344, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);
    push_beat(32'h100, 4'b1111, 1'b0, 32'h0); sb_res.push_back(32'h01020304);
    run_access("ns_lw_100", 1, 1'b0, LDST_W, 32'h100, 32'h0, 32'h01020304, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);
    sb_res.push_back(32'h01020304);
    run_access("ns_lh_201", 1, 1'b0, LDST_H, 32'h201, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0);

    // Reset during the second beat's response, then a clean access
    push_beat(32'h100, 4'b1100, 1'b0, 32'h0);
    push_beat(32'h104, 4'b0011, 1'b0, 32'h0);
    sb_res.push_back(32'h66665555);
    run_access("lw_abort", 0, 1'b0, LDST_W, 32'h102, 32'h0, 32'h55550000, 32'h00006666, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("abort_queue_drained", 32'(sb_beats.size()), 32'd0);

    push_beat(32'h104, 4'b1111, 1'b0, 32'h0); sb_res.push_back(32'h5A5A5A5A);
    run_access("lw_after_rst", 0, 1'b0, LDST_W, 32'h104, 32'h0, 32'h5A5A5A5A, 32'h0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
